// File: rtl/led_chaser_pkg.sv
// Shared encodings for the LED chaser: display modes, chase direction and button indices.
package led_chaser_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_BAR    = 2'b10;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int BTN_FWD  = 0;
  localparam int BTN_BACK = 1;
  localparam int BTN_RUN  = 2;
  localparam int BTN_DIR  = 3;
  localparam int N_BTN    = 4;

endpackage

// File: rtl/led_chaser_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse
// on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 240_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync0_q, sync1_q;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The counter only advances while the synchronised level disagrees with the
  // debounced one, so any bounce back restarts the stability window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync1_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync1_q;
      else                   cnt_d    = cnt_q + CNT_ONE;
    end
    press_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync0_q  <= btn_raw;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_chaser.sv
// LED position sequencer: debounced buttons, auto-step timer, WRAP/BOUNCE/BAR display.
// Optional LED_CHASER_SPEED_EN: auto period = STEP_DIV >> speed_sel.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LEDS       = 4,
  parameter int STEP_DIV     = 6_000_000,
  parameter int DEBOUNCE_CYC = 240_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                push_button,
  input  logic [1:0]                mode,
  input  logic [1:0]                speed_sel,
  output logic [N_LEDS-1:0]         led_out,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      running
);

  localparam int PW = $clog2(N_LEDS);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] LAST    = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + POS_ONE;
  endfunction

  function automatic logic [PW-1:0] dec_wrap(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - POS_ONE;
  endfunction

  logic [N_BTN-1:0] press;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (push_button[b]),
      .press   (press[b])
    );
  end

  logic [PW-1:0]     pos_q, pos_d;
  dir_e              dir_q, dir_d;
  logic              running_q, running_d;
  logic [CW-1:0]     cnt_q, cnt_d, term;
  logic [N_LEDS-1:0] led_out_q, led_out_d;
  logic              speed_chg, tick, fwd, back, step_f, step_b, go_up;

`ifdef LED_CHASER_SPEED_EN
  logic [1:0]  speed_q;
  logic [31:0] period;

  always_comb begin
    period = 32'(STEP_DIV) >> speed_sel;
    if (period == 32'd0) period = 32'd1;
    term      = CW'(period - 32'd1);
    speed_chg = (speed_sel != speed_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) speed_q <= 2'b00;
    else       speed_q <= speed_sel;
  end
`else
  logic unused_speed;
  assign unused_speed = ^speed_sel;
  assign term         = CW'(STEP_DIV - 1);
  assign speed_chg    = 1'b0;
`endif

  always_comb begin
    fwd    = press[BTN_FWD];
    back   = press[BTN_BACK];
    tick   = running_q && (cnt_q == term);
    // Simultaneous fwd+back cancels everything, including a coincident auto tick.
    step_f = (fwd & ~back) | (~fwd & ~back & tick);
    step_b = back & ~fwd;

    if (!running_q || fwd || back || speed_chg || tick) cnt_d = '0;
    else                                                cnt_d = cnt_q + CNT_ONE;

    running_d = running_q ^ press[BTN_RUN];
    pos_d     = pos_q;
    dir_d     = dir_q;
    go_up     = 1'b0;

    if (mode == MODE_BOUNCE) begin
      if (step_f) begin
        if (dir_q == DIR_UP) begin
          if (pos_q == LAST) begin
            pos_d = LAST - POS_ONE;
            dir_d = DIR_DOWN;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end else begin
          if (pos_q == '0) begin
            pos_d = POS_ONE;
            dir_d = DIR_UP;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end
      end else if (step_b) begin
        if (dir_q == DIR_UP) begin
          if (pos_q != '0) pos_d = pos_q - POS_ONE;
        end else begin
          if (pos_q != LAST) pos_d = pos_q + POS_ONE;
        end
      end
    end else if (step_f || step_b) begin
      go_up = (dir_q == DIR_UP) ^ step_b;
      pos_d = go_up ? inc_wrap(pos_q) : dec_wrap(pos_q);
    end

    // A direction press takes effect from the next step, after any bounce flip.
    if (press[BTN_DIR]) dir_d = (dir_d == DIR_UP) ? DIR_DOWN : DIR_UP;

    for (int i = 0; i < N_LEDS; i++) begin
      led_out_d[i] = (mode == MODE_BAR) ? (PW'(i) <= pos_q) : (PW'(i) == pos_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      running_q <= 1'b0;
      cnt_q     <= '0;
      led_out_q <= {{(N_LEDS-1){1'b0}}, 1'b1};
    end else begin
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign pos     = pos_q;
  assign running = running_q;

endmodule

// File: tb/tb_led_chaser.sv
// Directed self-checking bench for led_chaser (N_LEDS=4, STEP_DIV=8, DEBOUNCE_CYC=4).
module tb_led_chaser;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] pb;
  logic [1:0] mode;
  logic [1:0] speed_sel;
  logic [3:0] led_out;
  logic [1:0] pos;
  logic       running;

  int checks = 0;
  int errors = 0;

  led_chaser #(.N_LEDS(4), .STEP_DIV(8), .DEBOUNCE_CYC(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .push_button (pb),
    .mode        (mode),
    .speed_sel   (speed_sel),
    .led_out     (led_out),
    .pos         (pos),
    .running     (running)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_btn(input int b);
    pb[b] = 1'b1;
    cyc(10);
    pb[b] = 1'b0;
    cyc(10);
  endtask

  initial begin
    reset = 1'b1; pb = 4'b0000; mode = 2'b00; speed_sel = 2'b00;
    cyc(2);
    check("rst_led", 32'(led_out), 32'h1);
    check("rst_pos", 32'(pos), 32'h0);
    check("rst_run", 32'(running), 32'h0);
    reset = 1'b0;
    cyc(100);
    check("idle_led", 32'(led_out), 32'h1);
    check("idle_pos", 32'(pos), 32'h0);
    check("idle_run", 32'(running), 32'h0);

    // First forward press with latency checks
    pb[0] = 1'b1;
    cyc(7);
    check("fwd_lat_pre", 32'(pos), 32'h0);
    cyc(1);
    check("fwd_lat_pos", 32'(pos), 32'h1);
    check("fwd_led_lag", 32'(led_out), 32'h1);
    cyc(1);
    check("fwd_led1", 32'(led_out), 32'h2);
    cyc(1);
    pb[0] = 1'b0;
    cyc(10);
    press_btn(0); check("fwd_led2", 32'(led_out), 32'h4);
    press_btn(0); check("fwd_led3", 32'(led_out), 32'h8);
    press_btn(0); check("fwd_led4", 32'(led_out), 32'h1);
    press_btn(0); check("fwd_led5", 32'(led_out), 32'h2);

    // Glitch and simultaneous fwd/back
    pb[0] = 1'b1; cyc(2); pb[0] = 1'b0; cyc(12);
    check("glitch_pos", 32'(pos), 32'h1);
    pb = 4'b0011; cyc(10); pb = 4'b0000; cyc(10);
    check("both_pos", 32'(pos), 32'h1);
    check("both_led", 32'(led_out), 32'h2);

    // Auto run in BOUNCE
    mode = 2'b01;
    pb[2] = 1'b1;
    cyc(8);
    check("run_on", 32'(running), 32'h1);
    check("run_pos0", 32'(pos), 32'h1);
    cyc(2); pb[2] = 1'b0;
    cyc(5); check("tick_pre", 32'(pos), 32'h1);
    cyc(1); check("tick_pos2", 32'(pos), 32'h2);
    cyc(1); check("bounce_led", 32'(led_out), 32'h4);
    cyc(7); check("tick_pos3", 32'(pos), 32'h3);
    cyc(8); check("tick_pos2b", 32'(pos), 32'h2);
    cyc(8); check("tick_pos1", 32'(pos), 32'h1);
    cyc(8); check("tick_pos0", 32'(pos), 32'h0);
    cyc(8); check("tick_pos1b", 32'(pos), 32'h1);
    pb[2] = 1'b1;
    cyc(8);
    check("run_off", 32'(running), 32'h0);
    check("stop_pos", 32'(pos), 32'h2);
    cyc(2); pb[2] = 1'b0; cyc(10);
    check("stopped_pos", 32'(pos), 32'h2);
    check("pre_bar_led", 32'(led_out), 32'h4);

    // BAR mode and back press
    mode = 2'b10;
    cyc(1);
    check("bar_led", 32'(led_out), 32'h7);
    press_btn(1);
    check("bar_back_led", 32'(led_out), 32'h3);

    // Mode 11 acts as WRAP; direction toggle and wrap downward
    mode = 2'b11;
    cyc(1);
    check("m11_led", 32'(led_out), 32'h2);
    press_btn(3);
    press_btn(0);
    check("down_pos0", 32'(pos), 32'h0);
    press_btn(0);
    check("down_wrap_pos", 32'(pos), 32'h3);
    check("down_wrap_led", 32'(led_out), 32'h8);

    // BOUNCE back clamps at end, fwd follows dir
    mode = 2'b01;
    press_btn(1);
    check("clamp_pos", 32'(pos), 32'h3);
    press_btn(0);
    check("bfwd_pos", 32'(pos), 32'h2);
    check("bfwd_led", 32'(led_out), 32'h4);

    // Async reset mid-count and mid-debounce
    press_btn(2);
    check("run_on2", 32'(running), 32'h1);
    pb[0] = 1'b1;
    cyc(3);
    reset = 1'b1;
    #1;
    check("async_led", 32'(led_out), 32'h1);
    check("async_pos", 32'(pos), 32'h0);
    check("async_run", 32'(running), 32'h0);
    pb[0] = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(12);
    check("post_rst_pos", 32'(pos), 32'h0);
    check("post_rst_run", 32'(running), 32'h0);
    check("post_rst_led", 32'(led_out), 32'h1);

`ifdef LED_CHASER_SPEED_EN
    speed_sel = 2'b10;
    pb[2] = 1'b1;
    cyc(8);
    pb[2] = 1'b0;
    check("spd_run", 32'(running), 32'h1);
    check("spd_pos0", 32'(pos), 32'h0);
    cyc(2); check("spd_pos1", 32'(pos), 32'h1);
    cyc(2); check("spd_pos2", 32'(pos), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
